// File: rtl/taunt_pkg.sv
// Shared encodings, message index map and the fixed LCD text table for the taunt path.
// Every line is 60 ASCII characters, first character in the MSBs, padded with spaces.
package taunt_pkg;
  localparam int TXT_CHARS = 60;
  localparam int TXT_W     = 8 * TXT_CHARS;

  typedef enum logic [2:0] {
    GS_IDLE       = 3'd0,
    GS_ACTIVATING = 3'd1,
    GS_ACTIVATED  = 3'd2,
    GS_DETONATING = 3'd3,
    GS_FAILED     = 3'd4,
    GS_SUCCESS    = 3'd5
  } game_state_e;

  localparam logic [7:0] IDX_IDLE     = 8'd0;
  localparam logic [7:0] IDX_DETONATE = 8'd1;
  localparam logic [7:0] IDX_FAILED   = 8'd2;
  localparam logic [7:0] IDX_SUCCESS  = 8'd3;
  localparam logic [7:0] IDX_AMB_BASE = 8'd4;
  localparam int         N_AMB_DEF    = 5;
  localparam int         EV_BASE      = 4 + N_AMB_DEF;

  // Event text table shape: 7 channels x 2 variants; anything beyond reads as blank.
  localparam int EV_TXT_CH  = 7;
  localparam int EV_TXT_VAR = 2;

  function automatic int ev_base(input int n_amb);
    return 4 + n_amb;
  endfunction

  function automatic logic [TXT_W-1:0] spaces();
    return {TXT_CHARS{8'h20}};
  endfunction

  // A string literal lands in the LSBs; slide it up to the MSBs, filling with spaces.
  function automatic logic [TXT_W-1:0] pad_txt(input logic [TXT_W-1:0] s);
    logic [TXT_W-1:0] r;
    r = s;
    for (int i = 0; i < TXT_CHARS; i++)
      if (r[TXT_W-1 -: 8] == 8'h00) r = {r[TXT_W-9:0], 8'h20};
    return r;
  endfunction

  localparam logic [TXT_W-1:0] FIXED_TXT [4] = '{
    pad_txt("SYSTEM IDLE - AWAITING ARMING SEQUENCE"),
    pad_txt("DETONATION IMMINENT - SAY GOODBYE"),
    pad_txt("MISSION FAILED - BETTER LUCK IN THE NEXT LIFE"),
    pad_txt("MISSION SUCCESS - YOU GOT LUCKY THIS TIME")
  };

  localparam logic [TXT_W-1:0] AMB_TXT [8] = '{
    pad_txt("TICK TOCK..."),
    pad_txt("ARE YOUR HANDS SHAKING YET?"),
    pad_txt("I HAVE ALL DAY. YOU DO NOT."),
    pad_txt("TAKE YOUR TIME. OR DON'T."),
    pad_txt("SOMEONE IS SWEATING"),
    pad_txt("EVERY WIRE LOOKS THE SAME, DOESN'T IT?"),
    pad_txt("I CAN HEAR YOU THINKING"),
    pad_txt("PATIENCE IS NOT YOUR STRENGTH")
  };

  localparam logic [TXT_W-1:0] EV_TXT [14] = '{
    pad_txt("WRONG WIRE. BOLD CHOICE."),
    pad_txt("THAT WIRE WAS IMPORTANT"),
    pad_txt("FORGETFUL, ARE WE?"),
    pad_txt("MEMORY LIKE A GOLDFISH"),
    pad_txt("DOT DOT DASH... NOPE"),
    pad_txt("YOUR MORSE NEEDS WORK"),
    pad_txt("LOST IN THE MAZE AGAIN"),
    pad_txt("WALLS ARE NOT DOORS"),
    pad_txt("ACCESS DENIED. TRY HARDER."),
    pad_txt("THAT IS NOT THE PASSWORD"),
    pad_txt("ONE MINUTE LEFT. NO PRESSURE."),
    pad_txt("SIXTY SECONDS OF HOPE"),
    pad_txt("TEN SECONDS. SAY YOUR PRAYERS."),
    pad_txt("COUNTDOWN: TEN")
  };
endpackage

// File: rtl/taunt_arbiter_if.sv
// Taunt arbiter bus: game inputs from the center controller, message outputs to the text path.
interface taunt_arbiter_if #(
  parameter int N_EV  = 5,
  parameter int CHARS = 60
);
  logic                 tick_1sec;
  logic [31:0]          rnd;
  logic [2:0]           current_state;
  logic [N_EV-1:0]      ev_pulse;
  logic [7:0]           msg_idx;
  logic                 msg_new;
  logic [8*CHARS-1:0]   msg;
  logic                 busy;

  modport master (output tick_1sec, rnd, current_state, ev_pulse,
                  input  msg_idx, msg_new, msg, busy);
  modport slave  (input  tick_1sec, rnd, current_state, ev_pulse,
                  output msg_idx, msg_new, msg, busy);
endinterface

// File: rtl/taunt_rom.sv
// Index-to-text lookup with one registered output stage; unmapped indices read as spaces.
module taunt_rom
  import taunt_pkg::*;
#(
  parameter int N_EV  = 5,
  parameter int N_VAR = 2,
  parameter int N_AMB = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       idx_i,
  output logic [TXT_W-1:0] txt_o
);
  localparam int EVB = ev_base(N_AMB);

  logic [TXT_W-1:0] txt_d;
  int               off, ev_k, ev_v;

  always_comb begin
    txt_d = spaces();
    off   = 0;
    ev_k  = 0;
    ev_v  = 0;
    if (idx_i < IDX_AMB_BASE) begin
      txt_d = FIXED_TXT[idx_i[1:0]];
    end else if (int'(idx_i) < EVB) begin
      off   = int'(idx_i) - int'(IDX_AMB_BASE);
      txt_d = AMB_TXT[off[2:0]];
    end else begin
      off  = int'(idx_i) - EVB;
      ev_k = off / N_VAR;
      ev_v = off % N_VAR;
      if (ev_k < N_EV && ev_k < EV_TXT_CH && ev_v < EV_TXT_VAR)
        txt_d = EV_TXT[4'(ev_k * EV_TXT_VAR + ev_v)];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) txt_o <= FIXED_TXT[0];
    else      txt_o <= txt_d;
  end
endmodule

// File: rtl/taunt_arbiter.sv
// Arbitrates event strobes, ambient chatter and forced game-state messages with a tick-based
// hold time; drives the message index immediately and the text one cycle later.
module taunt_arbiter
  import taunt_pkg::*;
#(
  parameter int N_EV     = 5,
  parameter int N_VAR    = 2,
  parameter int N_AMB    = 5,
  parameter int HOLD_SEC = 5,
  parameter int CHARS    = 60
) (
  input logic            clk,
  input logic            rst,
  taunt_arbiter_if.slave bus
);
  localparam int         EVB  = ev_base(N_AMB);
  localparam logic [7:0] HOLD = 8'(HOLD_SEC);

  if (CHARS != TXT_CHARS) begin : g_bad_chars
    $error("taunt_arbiter: CHARS must match the 60-character text table");
  end
  if (N_VAR < 1 || (N_VAR & (N_VAR - 1)) != 0) begin : g_bad_var
    $error("taunt_arbiter: N_VAR must be a power of two");
  end
  if (N_AMB < 1 || N_AMB > 8) begin : g_bad_amb
    $error("taunt_arbiter: N_AMB must be 1..8");
  end
  if (HOLD_SEC < 1 || HOLD_SEC > 255) begin : g_bad_hold
    $error("taunt_arbiter: HOLD_SEC must be 1..255");
  end
  if (EVB + N_EV * N_VAR > 256) begin : g_bad_map
    $error("taunt_arbiter: message index map exceeds 8 bits");
  end

  logic [N_EV-1:0] pend_q, pend_d, req, lo_oh;
  logic            show_q, show_d, new_q, new_d;
  logic [7:0]      hold_q, hold_d, idx_q, idx_d;
  logic [7:0]      fixed_idx, lo_k, var_v, amb_v;
  logic            forced, expired;
  logic            unused_rnd;

  assign req        = pend_q | bus.ev_pulse;
  assign expired    = (hold_q == HOLD);
  assign var_v      = bus.rnd[7:0] & 8'(N_VAR - 1);
  assign amb_v      = bus.rnd[7:0] % 8'(N_AMB);
  assign unused_rnd = ^bus.rnd[31:8];

  // Only the two play states arbitrate; everything else, including 6/7, pins a fixed line.
  always_comb begin
    forced    = 1'b1;
    fixed_idx = IDX_IDLE;
    case (game_state_e'(bus.current_state))
      GS_ACTIVATING, GS_ACTIVATED: forced = 1'b0;
      GS_DETONATING:               fixed_idx = IDX_DETONATE;
      GS_FAILED:                   fixed_idx = IDX_FAILED;
      GS_SUCCESS:                  fixed_idx = IDX_SUCCESS;
      default:                     fixed_idx = IDX_IDLE;
    endcase
  end

  // Lowest set channel wins: scan downward so the last hit is the lowest index.
  always_comb begin
    lo_k  = '0;
    lo_oh = '0;
    for (int i = N_EV - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_k  = 8'(i);
        lo_oh = '0;
        lo_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pend_d = pend_q;
    show_d = show_q;
    hold_d = hold_q;
    idx_d  = idx_q;
    new_d  = 1'b0;
    if (forced) begin
      pend_d = '0;
      show_d = 1'b0;
      hold_d = HOLD;
      idx_d  = fixed_idx;
      new_d  = (fixed_idx != idx_q);
    end else if (|req && (expired || !show_q)) begin
      idx_d  = 8'(EVB) + 8'(int'(lo_k) * N_VAR) + var_v;
      pend_d = req & ~lo_oh;
      show_d = 1'b1;
      hold_d = '0;
      new_d  = 1'b1;
    end else if (!(|req) && expired) begin
      idx_d  = IDX_AMB_BASE + amb_v;
      show_d = 1'b0;
      hold_d = '0;
      new_d  = 1'b1;
    end else begin
      pend_d = req;
      if (bus.tick_1sec && !expired) hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      show_q <= 1'b0;
      hold_q <= HOLD;
      idx_q  <= IDX_IDLE;
      new_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      show_q <= show_d;
      hold_q <= hold_d;
      idx_q  <= idx_d;
      new_q  <= new_d;
    end
  end

  assign bus.msg_idx = idx_q;
  assign bus.msg_new = new_q;
  assign bus.busy    = !expired;

  taunt_rom #(.N_EV(N_EV), .N_VAR(N_VAR), .N_AMB(N_AMB)) u_rom (
    .clk  (clk),
    .rst  (rst),
    .idx_i(idx_q),
    .txt_o(bus.msg)
  );
endmodule

// File: doc/taunt_arbiter.md
# taunt_arbiter

Parametrised successor to the bomb's single-channel taunt generator. It arbitrates N_EV mistake or warning event channels against random ambient chatter and forced game-state messages, with a tick-based hold time. It outputs a message index and the matching 60-character ASCII line for the LCD/VGA text path. It sits beside the center controller and consumes its state, the shared 1 s tick and the LFSR random word.

## Interface
Parameters:
- N_EV, 5: number of event channels; channel 0 has the highest priority.
- N_VAR, 2: text variants per event channel, power of two, ≥1.
- N_AMB, 5: ambient variants for ACTIVATING/ACTIVATED, 1..8.
- HOLD_SEC, 5: minimum display time in tick_1sec pulses, 1..255.
- CHARS, 60: characters per line.

Ports:
- clk, in, 1: system clock. The block has one clock.
- rst, in, 1: reset, asynchronous and active-low.
- tick_1sec, in, 1: one-cycle pulse once per second.
- rnd, in, 32: free-running random word.
- current_state, in, 3: center-controller state (IDLE=0, ACTIVATING=1, ACTIVATED=2, DETONATING=3, MISSION_FAILED=4, MISSION_SUCCESSED=5).
- ev_pulse, in, N_EV: one-cycle event strobes (wire/memory/morse/maze/password mistake, one-minute, ten-second).
- msg_idx, out, 8: index of the selected message.
- msg_new, out, 1: one-cycle pulse whenever msg_idx is loaded.
- msg, out, 8*CHARS: ASCII text; first character in the MSBs, right-padded with spaces.
- busy, out, 1: hold timer not yet expired.

## Operation
- Index map (shared package):
  - 0..3: IDLE, DETONATING, FAILED, SUCCESS.
  - 4..4+N_AMB-1: ambient messages.
  - EV_BASE=4+N_AMB; event k, variant v at EV_BASE+k*N_VAR+v.
- State is pend[N_EV], show_ev (1 = current message is an event), and hold_cnt (0..HOLD_SEC, saturating).
- Expired means hold_cnt==HOLD_SEC. busy = !expired.
- Forced mode (current_state ∈ {0,3,4,5}; 6,7 treated as IDLE):
  - msg_idx = fixed index; pend is cleared; ev_pulse is dropped; hold_cnt = HOLD_SEC; show_ev = 0.
  - msg_new pulses only on the cycle the fixed index changes.
- Play mode (state 1 or 2). Per cycle, req = pend | ev_pulse.
  - If req≠0 and (expired or !show_ev): load the lowest set channel k with v = rnd[log2(N_VAR)-1:0]. Clear pend[k]; the other req bits stay in pend. Set show_ev=1.
  - Else if req==0 and expired: load ambient rnd[7:0] % N_AMB, show_ev=0.
  - Else: pend |= ev_pulse.
- Any load sets hold_cnt=0 and pulses msg_new. The load wins over a same-cycle tick_1sec.
- Otherwise tick_1sec increments hold_cnt until it saturates.
- A strobe on an already-pending channel is absorbed: there is one pending slot per channel.
- Events preempt ambient chatter immediately. They never preempt another event until that event's hold expires.
- Transitions between states 1 and 2 have no effect.
- Leaving forced mode into play mode selects an ambient message or a pending event on the next cycle, because the counter is already expired.

## Timing
- Reset values: msg_idx=0, msg=IDLE text, msg_new=0, busy=0, pend=0, show_ev=0, hold_cnt=HOLD_SEC.
- Reset is honoured mid-message. All text is lost; no deferred events survive.
- ev_pulse sampled at edge E → msg_idx and msg_new update at E.
- msg text updates at E+1, through the registered ROM. msg_new is not aligned with msg; consumers latch msg one cycle after msg_new.
- Ambient messages are reissued every HOLD_SEC ticks while no event is pending.
- Arithmetic: the modulo uses rnd[7:0] only. Index sums are computed in 8 bits; the elaboration check requires EV_BASE+N_EV*N_VAR ≤ 256.

## Structure
- Package taunt_pkg holds:
  - game-state encodings;
  - IDX_* constants and EV_BASE;
  - the space-padded 480-bit string constants;
  - a function returning the pad/space fill.
- Sub-module taunt_rom holds the index-to-text lookup, with one registered output stage. Unmapped indices return all spaces.
- taunt_arbiter holds the pending bits, priority encoder, hold counter and selection logic.

## Test plan
- Reset released in IDLE: msg_idx=0, IDLE text at msg, no msg_new. Move to ACTIVATING: next cycle msg_new=1, msg_idx = 4 + rnd[7:0]%5 (rnd=0x07 → 6).
- ACTIVATING with an ambient message showing, ev_pulse=5'b00100, rnd=1: msg_idx = EV_BASE+2*2+1 = 14 in the same edge; busy=1.
- Event showing; ev_pulse 5'b00001 then 5'b10000 after 1 tick: no reload until 5 ticks. Then channel 0 loads (idx 9/10), then channel 4 after 5 more ticks (idx 17/18).
- ev_pulse=5'b00110 in one cycle: channel 1 loads; channel 2 pends and loads after hold expiry.
- Event pending, state → DETONATING: msg_idx=1, pend cleared, DETONATING text next cycle, busy=0.
- rst low during hold (hold_cnt=2): outputs return to reset values asynchronously.
